// File: rtl/counter_pkg.sv
// Shared definitions for the button-driven 0..MAX_COUNT counter.
//   mode_t            : operating mode of the counter FSM
//   DEFAULT_MAX_COUNT : highest count value before wrapping to 0
//   DEFAULT_TICK_DIV  : clk cycles per AUTO increment (1 s at 50 MHz)
//   DEFAULT_CNT_W     : counter width, 2**CNT_W must exceed MAX_COUNT
//   BCD_W             : width of one BCD digit
package counter_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  localparam int DEFAULT_MAX_COUNT = 19;
  localparam int DEFAULT_TICK_DIV  = 50_000_000;
  localparam int DEFAULT_CNT_W     = 5;
  localparam int BCD_W             = 4;

endpackage

// File: rtl/btn_counter_0_19_if.sv
// Signal bundle between the debounce stage, the counter and the display stage.
//   btn_inc_clean / btn_dec_clean / btn_mode_clean : debounced button levels
//   count                                          : current count (binary)
//   bcd_tens / bcd_ones                            : decimal digits of count
//   auto_mode                                      : 1 while counting automatically
//   wrap                                           : one-cycle wrap-around pulse
// master: drives the buttons and observes the display outputs.
// slave : the counter, consumes the buttons and drives the outputs.
interface btn_counter_0_19_if
  import counter_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             btn_inc_clean;
  logic             btn_dec_clean;
  logic             btn_mode_clean;
  logic [CNT_W-1:0] count;
  logic [BCD_W-1:0] bcd_tens;
  logic [BCD_W-1:0] bcd_ones;
  logic             auto_mode;
  logic             wrap;

  modport master (
    output btn_inc_clean,
    output btn_dec_clean,
    output btn_mode_clean,
    input  count,
    input  bcd_tens,
    input  bcd_ones,
    input  auto_mode,
    input  wrap
  );

  modport slave (
    input  btn_inc_clean,
    input  btn_dec_clean,
    input  btn_mode_clean,
    output count,
    output bcd_tens,
    output bcd_ones,
    output auto_mode,
    output wrap
  );

endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector for one debounced button level.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   level : debounced level, synchronous to clk
//   pulse : high for the cycle in which level is 1 and was 0 one cycle earlier
// The history flop resets to 1 so a button held through reset does not
// produce an event when reset is released.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else begin
      prev <= level;
    end
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/btn_counter_0_19.sv
// Modulo-(MAX_COUNT+1) counter stepped by buttons (MANUAL) or by a prescaled
// tick (AUTO), with binary and BCD outputs for the display stage.
//   clk   : system clock, all state changes on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of btn_counter_0_19_if
//           inputs  btn_inc_clean, btn_dec_clean, btn_mode_clean
//           outputs count, bcd_tens, bcd_ones, auto_mode, wrap
// A mode event toggles MANUAL<->AUTO; any count change in that same cycle
// follows the rules of the mode being left.
module btn_counter_0_19
  import counter_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT,  // 1..99
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,   // >= 1
  parameter int CNT_W     = DEFAULT_CNT_W       // 2**CNT_W > MAX_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  btn_counter_0_19_if.slave bus
);

  // A divide-by-1 prescaler still needs one bit to exist; it simply never
  // leaves 0, so the tick fires every AUTO cycle.
  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

  // ---------------------------------------------------------------------------
  // Button events
  // ---------------------------------------------------------------------------
  logic ev_inc;
  logic ev_dec;
  logic ev_mode;

  edge_rise u_edge_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.btn_inc_clean),
    .pulse (ev_inc)
  );

  edge_rise u_edge_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.btn_dec_clean),
    .pulse (ev_dec)
  );

  edge_rise u_edge_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.btn_mode_clean),
    .pulse (ev_mode)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mode_t            mode_q;
  logic             auto_q;
  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] count_q;
  logic             wrap_q;

  // Step requests, decided by the mode the FSM is in before this edge.
  logic tick;
  logic step_up;
  logic step_dn;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    tick    = 1'b0;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (mode_q == MODE_AUTO) begin
      tick    = (pre_q == PRE_LAST);
      step_up = tick;
    end else begin
      // Simultaneous inc and dec cancel each other.
      step_up = ev_inc & ~ev_dec;
      step_dn = ev_dec & ~ev_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_MANUAL;
      auto_q  <= 1'b0;
      pre_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;

      if (step_up) begin
        if (count_q == CNT_MAX) begin
          count_q <= '0;
          wrap_q  <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end else if (step_dn) begin
        if (count_q == '0) begin
          count_q <= CNT_MAX;
          wrap_q  <= 1'b1;
        end else begin
          count_q <= count_q - 1'b1;
        end
      end

      if (ev_mode) begin
        // Entering AUTO starts a fresh prescaler period; leaving AUTO parks
        // the prescaler at 0.
        mode_q <= (mode_q == MODE_MANUAL) ? MODE_AUTO : MODE_MANUAL;
        auto_q <= (mode_q == MODE_MANUAL);
        pre_q  <= '0;
      end else if (mode_q == MODE_AUTO) begin
        pre_q <= tick ? '0 : pre_q + 1'b1;
      end else begin
        pre_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BCD decode: repeated subtraction of a constant 10. Nine steps cover any
  // count up to 99.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0] tens;
  logic [7:0]       rem;

  always_comb begin
    rem  = 8'(count_q);
    tens = '0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 8'd10) begin
        rem  = rem - 8'd10;
        tens = tens + 1'b1;
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.bcd_tens  = tens;
  assign bus.bcd_ones  = rem[BCD_W-1:0];
  assign bus.auto_mode = auto_q;
  assign bus.wrap      = wrap_q;

endmodule
